// File: rtl/smm0.sv
// Leaf Strassen 2x2 signed matrix multiplier with a matrix-vector mode.
// Four register stages from load to C_out: input capture, T/S operands, products M, result C.
module smm0 #(
  parameter int DATAWIDTH = 32,
  parameter int BLOCKSIZE = 128,
  parameter int BUSWIDTH  = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BLOCKSIZE-1:0] A,
  input  logic [BLOCKSIZE-1:0] B,
  input  logic                 load,
  input  logic                 sel,
  output logic [BLOCKSIZE-1:0] C_out
);

  localparam int DW = DATAWIDTH;

  generate
    if (BLOCKSIZE != 4 * DATAWIDTH || BUSWIDTH != BLOCKSIZE) begin : g_bad_params
      $error("smm0: BLOCKSIZE must be 4*DATAWIDTH and BUSWIDTH must equal BLOCKSIZE");
    end
  endgenerate

  // Input capture register: the load edge samples A/B/sel, so the result lands after edge k+3.
  logic [BLOCKSIZE-1:0] a_reg, b_reg;
  logic                 load_reg, sel_in_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      load_reg   <= 1'b0;
      sel_in_reg <= 1'b0;
    end else begin
      load_reg <= load;
      if (load) begin
        a_reg      <= A;
        b_reg      <= B;
        sel_in_reg <= sel;
      end
    end
  end

  logic signed [DW-1:0] a_e [4];
  logic signed [DW-1:0] b_e [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign a_e[gi] = a_reg[gi*DW +: DW];
      assign b_e[gi] = b_reg[gi*DW +: DW];
    end
  endgenerate

  // Stage 1: Strassen operand sums
  logic signed [DW-1:0] t_next [7];
  logic signed [DW-1:0] s_next [7];
  logic signed [DW-1:0] b01_eff, b11_eff;

  always_comb begin
    // Vector mode reuses column 0 of B as both columns.
    b01_eff = sel_in_reg ? b_e[0] : b_e[1];
    b11_eff = sel_in_reg ? b_e[2] : b_e[3];

    t_next[0] = a_e[0] + a_e[3];
    t_next[1] = a_e[2] + a_e[3];
    t_next[2] = a_e[0];
    t_next[3] = a_e[3];
    t_next[4] = a_e[0] + a_e[1];
    t_next[5] = a_e[2] - a_e[0];
    t_next[6] = a_e[1] - a_e[3];

    s_next[0] = b_e[0] + b11_eff;
    s_next[1] = b_e[0];
    s_next[2] = b01_eff - b11_eff;
    s_next[3] = b_e[2] - b_e[0];
    s_next[4] = b11_eff;
    s_next[5] = b_e[0] + b01_eff;
    s_next[6] = b_e[2] + b11_eff;

    if (sel_in_reg) begin
      t_next[0] = '0;
      t_next[5] = '0;
      t_next[6] = '0;
      s_next[0] = '0;
      s_next[5] = '0;
      s_next[6] = '0;
    end
  end

  logic signed [DW-1:0] t_reg [7];
  logic signed [DW-1:0] s_reg [7];
  logic                 sel_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) begin
        t_reg[i] <= '0;
        s_reg[i] <= '0;
      end
      sel_q_reg <= 1'b0;
    end else if (load_reg) begin
      for (int i = 0; i < 7; i++) begin
        t_reg[i] <= t_next[i];
        s_reg[i] <= s_next[i];
      end
      sel_q_reg <= sel_in_reg;
    end
  end

  // Stage 2: seven products, truncated to DW bits
  logic signed [DW-1:0] prod [7];
  logic signed [DW-1:0] m_reg [7];
  logic                 sel_m_reg;

  generate
    for (gi = 0; gi < 7; gi++) begin : g_mul
      assign prod[gi] = t_reg[gi] * s_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) m_reg[i] <= '0;
      sel_m_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) m_reg[i] <= prod[i];
      sel_m_reg <= sel_q_reg;
    end
  end

  // Stage 3: recombination
  logic signed [DW-1:0] c00_next, c01_next, c10_next, c11_next;

  always_comb begin
    c10_next = m_reg[1] + m_reg[3];
    if (sel_m_reg) begin
      c00_next = m_reg[2] + m_reg[4];
      c01_next = '0;
      c11_next = '0;
    end else begin
      c00_next = m_reg[0] + m_reg[3] - m_reg[4] + m_reg[6];
      c01_next = m_reg[2] + m_reg[4];
      c11_next = m_reg[0] - m_reg[1] + m_reg[2] + m_reg[5];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) C_out <= '0;
    else     C_out <= {c11_next, c10_next, c01_next, c00_next};
  end

endmodule

// File: tb/tb_smm0.sv
// Self-checking bench for smm0: directed spec cases plus random traffic checked
// every cycle against a plain-arithmetic matrix model with a 3-edge latency rule.
module tb_smm0;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] A, B;
  logic         load, sel;
  logic [127:0] C_out;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  bit           load_at [0:1023];
  bit           rst_at  [0:1023];
  logic [127:0] res_at  [0:1023];

  smm0 dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .load  (load),
    .sel   (sel),
    .C_out (C_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack(input int x00, input int x01, input int x10, input int x11);
    logic [31:0] e0, e1, e2, e3;
    e0 = x00; e1 = x01; e2 = x10; e3 = x11;
    return {e3, e2, e1, e0};
  endfunction

  // Direct row-by-column product; int arithmetic wraps at 32 bits.
  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b, input bit s);
    int ma [2][2];
    int mb [2][2];
    int mc [2][2];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ma[r][c] = a[(r*2+c)*32 +: 32];
        mb[r][c] = b[(r*2+c)*32 +: 32];
      end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        mc[r][c] = (s && c == 1) ? 0 : ma[r][0] * mb[0][c] + ma[r][1] * mb[1][c];
    return pack(mc[0][0], mc[0][1], mc[1][0], mc[1][1]);
  endfunction

  // C after edge e: result of the newest load at or before e-3 that no later reset discarded.
  function automatic logic [127:0] expected(input int e);
    int last_rst;
    last_rst = 0;
    for (int r = 1; r <= e; r++) if (rst_at[r]) last_rst = r;
    for (int k = e - 3; k > last_rst; k--)
      if (load_at[k]) return res_at[k];
    return '0;
  endfunction

  task automatic cycle(input bit r, input bit ld, input logic [127:0] a, input logic [127:0] b,
                       input bit s, input string tag);
    logic [127:0] exp_c;
    rst = r; load = ld; A = a; B = b; sel = s;
    @(posedge clk);
    edge_n++;
    rst_at[edge_n]  = r;
    load_at[edge_n] = ld && !r;
    res_at[edge_n]  = model(a, b, s);
    #1;
    exp_c = expected(edge_n);
    checks++;
    assert (C_out === exp_c) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, C_out, exp_c);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom(), $urandom(), $urandom_range(0, 1), tag);
  endtask

  task automatic check_const(input logic [127:0] want, input string tag);
    checks++;
    assert (C_out === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, C_out, want);
    end
  endtask

  initial begin
    logic [127:0] ra, rb;
    rst = 1'b1; load = 1'b0; A = '0; B = '0; sel = 1'b0;

    cycle(1'b1, 1'b1, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b0, "reset");
    cycle(1'b1, 1'b0, '0, '0, 1'b0, "reset");
    check_const('0, "reset_zero");
    idle(2, "post_reset");

    cycle(1'b0, 1'b1, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b0, "mm_load");
    idle(3, "mm_wait");
    check_const(pack(19, 22, 43, 50), "mm_const");
    idle(2, "mm_hold");
    check_const(pack(19, 22, 43, 50), "mm_hold_const");

    cycle(1'b0, 1'b1, pack(1, 2, 3, 4), pack(5, 99, 7, 99), 1'b1, "mv_load");
    idle(3, "mv_wait");
    check_const(pack(19, 0, 43, 0), "mv_const");

    cycle(1'b0, 1'b1, pack(-1, 2, 3, -4), pack(1, 0, 0, 1), 1'b0, "signed_id");
    idle(3, "signed_id_wait");
    check_const(pack(-1, 2, 3, -4), "signed_id_const");

    cycle(1'b0, 1'b1, pack(-1, 2, 3, -4), pack(0, -1, -1, 0), 1'b0, "signed_swap");
    idle(3, "signed_swap_wait");
    check_const(pack(-2, 1, 4, -3), "signed_swap_const");

    cycle(1'b0, 1'b1, pack(32'h7FFFFFFF, 0, 0, 0), pack(2, 0, 0, 0), 1'b0, "wrap");
    idle(3, "wrap_wait");
    check_const(pack(32'hFFFFFFFE, 0, 0, 0), "wrap_const");

    cycle(1'b0, 1'b1, pack(1, 1, 1, 1), pack(2, 3, 4, 5), 1'b0, "stream0");
    cycle(1'b0, 1'b1, pack(-3, 7, 2, 0), pack(6, -1, 1, 9), 1'b1, "stream1");
    cycle(1'b0, 1'b1, pack(10, -20, 30, -40), pack(-2, 4, 3, 1), 1'b0, "stream2");
    idle(2, "stream_wait");
    idle(1, "stream_first");
    idle(2, "stream_rest");
    check_const(pack(10 * -2 + -20 * 3, 10 * 4 + -20 * 1, 30 * -2 + -40 * 3, 30 * 4 + -40 * 1),
                "stream_hold_const");

    cycle(1'b0, 1'b1, pack(9, 8, 7, 6), pack(5, 4, 3, 2), 1'b0, "rst_mid_load");
    cycle(1'b1, 1'b0, '0, '0, 1'b0, "rst_mid");
    idle(4, "rst_mid_after");
    check_const('0, "rst_mid_const");

    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        ra = {$urandom(), $urandom(), $urandom(), $urandom()};
        rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        ra = pack($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                  $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100);
        rb = pack($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                  $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100);
      end
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, ra, rb,
            $urandom_range(0, 1), "random");
    end
    idle(4, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
